// File: rtl/configure.sv
// Shared configuration for the memory decoder: FSM state type, default slave address map
// and the slave-index width helper.
package configure;

    // Decoder FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StErr  = 2'd2
    } dec_state_e;

    // SoC slave windows: base inclusive, top exclusive
    localparam logic [31:0] RomBase   = 32'h0000_0000;
    localparam logic [31:0] RomTop    = 32'h0001_0000;
    localparam logic [31:0] UartBase  = 32'h0010_0000;
    localparam logic [31:0] UartTop   = 32'h0010_0100;
    localparam logic [31:0] ClintBase = 32'h0020_0000;
    localparam logic [31:0] ClintTop  = 32'h0020_C000;
    localparam logic [31:0] AxiBase   = 32'h8000_0000;
    localparam logic [31:0] AxiTop    = 32'h9000_0000;

    localparam int unsigned DefaultNumSlv = 4;

    // Index 0 sits in the LSBs, so the concatenation lists slave 3 first
    localparam logic [DefaultNumSlv-1:0][31:0] DefaultBaseAddr =
        {AxiBase, ClintBase, UartBase, RomBase};
    localparam logic [DefaultNumSlv-1:0][31:0] DefaultTopAddr =
        {AxiTop, ClintTop, UartTop, RomTop};

    // Width of a slave index, never less than one bit
    function automatic int unsigned sel_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/decode_timer.sv
// BUSY-state watchdog for mem_decoder (used only when DECODER_TIMEOUT_EN is defined).
// The counter holds the number of completed BUSY cycles; expire_o fires during the BUSY
// cycle whose incremented count would reach TIMEOUT-1.
module decode_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 2);

    logic [CntW-1:0] count_q, count_d;

    // Next count: clear on BUSY entry, step on every BUSY cycle
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry flag for the current BUSY cycle
    always_comb begin
        expire_o = enable_i && (count_q == LastCnt);
    end

endmodule

// File: rtl/mem_decoder.sv
// Stateful memory-port address decoder: routes one request at a time to the slave whose
// window contains the address, returns only that slave's response, and answers unmapped
// addresses with an error. Define DECODER_TIMEOUT_EN to also force an error response when
// the selected slave stays silent for TIMEOUT cycles.
module mem_decoder
    import configure::*;
#(
    parameter int unsigned                    NUM_SLV   = DefaultNumSlv,
    parameter logic [NUM_SLV-1:0][31:0]       BASE_ADDR = DefaultBaseAddr,
    parameter logic [NUM_SLV-1:0][31:0]       TOP_ADDR  = DefaultTopAddr,
    parameter int unsigned                    TIMEOUT   = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      memory_valid,
    input  logic                      memory_instr,
    input  logic [31:0]               memory_addr,
    input  logic [31:0]               memory_wdata,
    input  logic [3:0]                memory_wstrb,
    output logic [31:0]               memory_rdata,
    output logic                      memory_ready,
    output logic                      memory_error,
    output logic [NUM_SLV-1:0]        slave_valid,
    output logic                      slave_instr,
    output logic [31:0]               slave_addr,
    output logic [31:0]               slave_wdata,
    output logic [3:0]                slave_wstrb,
    input  logic [NUM_SLV-1:0][31:0]  slave_rdata,
    input  logic [NUM_SLV-1:0]        slave_ready
);

    localparam int unsigned SelW = sel_width(NUM_SLV);

    dec_state_e        state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [NUM_SLV-1:0] hit;
    logic [SelW-1:0]   hit_idx;
    logic              any_hit;
    logic              timer_clear;
    logic              timer_expire;

    // Window match per slave, unsigned 32-bit compares
    always_comb begin
        for (int i = 0; i < NUM_SLV; i++) begin
            hit[i] = (memory_addr >= BASE_ADDR[i]) && (memory_addr < TOP_ADDR[i]);
        end
    end

    // Priority encode: the lowest matching index wins overlapping windows
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = SelW'(i);
                any_hit = 1'b1;
            end
        end
    end

    // Broadcast request fields, address rebased to the selected window
    always_comb begin
        slave_instr = memory_instr;
        slave_addr  = memory_addr - BASE_ADDR[hit_idx];
        slave_wdata = memory_wdata;
        slave_wstrb = memory_wstrb;
    end

`ifdef DECODER_TIMEOUT_EN
    decode_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_decode_timer (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (timer_clear),
        .enable_i (state_q == StBusy),
        .expire_o (timer_expire)
    );
`else
    assign timer_expire = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{timer_clear, 32'(TIMEOUT)};
`endif

    // Next-state, slave request and response generation; all outputs held low in reset
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        timer_clear  = 1'b0;
        slave_valid  = '0;
        memory_ready = 1'b0;
        memory_error = 1'b0;
        memory_rdata = '0;

        unique case (state_q)
            StIdle: begin
                if (memory_valid) begin
                    if (any_hit) begin
                        slave_valid[hit_idx] = 1'b1;
                        sel_d                = hit_idx;
                        if (slave_ready[hit_idx]) begin
                            memory_ready = 1'b1;
                            memory_rdata = slave_rdata[hit_idx];
                        end else begin
                            state_d     = StBusy;
                            timer_clear = 1'b1;
                        end
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StBusy: begin
                // A real response beats a timeout landing in the same cycle
                if (slave_ready[sel_q]) begin
                    memory_ready = 1'b1;
                    memory_rdata = slave_rdata[sel_q];
                    state_d      = StIdle;
                end else if (timer_expire) begin
                    memory_ready = 1'b1;
                    memory_error = 1'b1;
                    state_d      = StIdle;
                end
            end
            StErr: begin
                memory_ready = 1'b1;
                memory_error = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!reset) begin
            slave_valid  = '0;
            memory_ready = 1'b0;
            memory_error = 1'b0;
            memory_rdata = '0;
        end
    end

    // State and selected-slave registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_mem_decoder.sv
// Directed bench for mem_decoder with a transaction-level reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_mem_decoder;

    localparam int TB_TIMEOUT = 8;

    logic              clock;
    logic              reset;
    logic              memory_valid;
    logic              memory_instr;
    logic [31:0]       memory_addr;
    logic [31:0]       memory_wdata;
    logic [3:0]        memory_wstrb;
    logic [31:0]       memory_rdata;
    logic              memory_ready;
    logic              memory_error;
    logic [3:0]        slave_valid;
    logic              slave_instr;
    logic [31:0]       slave_addr;
    logic [31:0]       slave_wdata;
    logic [3:0]        slave_wstrb;
    logic [3:0][31:0]  slave_rdata;
    logic [3:0]        slave_ready;

    int n_checks = 0;
    int n_errors = 0;

    mem_decoder #(
        .NUM_SLV   (4),
        .BASE_ADDR ({32'h8000_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000}),
        .TOP_ADDR  ({32'h9000_0000, 32'h0020_C000, 32'h0010_0100, 32'h0001_0000}),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready),
        .memory_error (memory_error),
        .slave_valid  (slave_valid),
        .slave_instr  (slave_instr),
        .slave_addr   (slave_addr),
        .slave_wdata  (slave_wdata),
        .slave_wstrb  (slave_wstrb),
        .slave_rdata  (slave_rdata),
        .slave_ready  (slave_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: address map table plus outstanding-transaction bookkeeping
    logic [31:0] win_base [4] = '{32'h0000_0000, 32'h0010_0000, 32'h0020_0000, 32'h8000_0000};
    logic [31:0] win_top  [4] = '{32'h0001_0000, 32'h0010_0100, 32'h0020_C000, 32'h9000_0000};
    int m_pend = -1;   // slave awaited, -1 when nothing outstanding
    bit m_err  = 1'b0; // decode error owed next cycle
    int m_wait = 0;    // BUSY cycles elapsed for the outstanding request

    always @(negedge clock) begin : model
        logic [3:0]  e_sv;
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_saddr;
        int          hit;
        e_sv    = '0;
        e_rdy   = 1'b0;
        e_err   = 1'b0;
        e_rdata = '0;
        e_saddr = '0;
        if (!reset) begin
            m_pend = -1;
            m_err  = 1'b0;
        end else if (m_err) begin
            e_rdy = 1'b1;
            e_err = 1'b1;
            m_err = 1'b0;
        end else if (m_pend >= 0) begin
            m_wait++;
            if (slave_ready[m_pend]) begin
                e_rdy   = 1'b1;
                e_rdata = slave_rdata[m_pend];
                m_pend  = -1;
            end
`ifdef DECODER_TIMEOUT_EN
            else if (m_wait == TB_TIMEOUT - 1) begin
                e_rdy  = 1'b1;
                e_err  = 1'b1;
                m_pend = -1;
            end
`endif
        end else if (memory_valid) begin
            hit = -1;
            for (int i = 3; i >= 0; i--) begin
                if (memory_addr >= win_base[i] && memory_addr < win_top[i]) hit = i;
            end
            if (hit < 0) begin
                m_err = 1'b1;
            end else begin
                e_sv[hit] = 1'b1;
                e_saddr   = memory_addr - win_base[hit];
                if (slave_ready[hit]) begin
                    e_rdy   = 1'b1;
                    e_rdata = slave_rdata[hit];
                end else begin
                    m_pend = hit;
                    m_wait = 0;
                end
            end
        end
        chk("model_ready", 32'(memory_ready), 32'(e_rdy));
        chk("model_error", 32'(memory_error), 32'(e_err));
        chk("model_rdata", memory_rdata, e_rdata);
        chk("model_slave_valid", 32'(slave_valid), 32'(e_sv));
        if (e_sv != '0) begin
            chk("model_slave_addr", slave_addr, e_saddr);
            chk("model_slave_wdata", slave_wdata, memory_wdata);
            chk("model_slave_wstrb", 32'(slave_wstrb), 32'(memory_wstrb));
            chk("model_slave_instr", 32'(slave_instr), 32'(memory_instr));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        memory_valid = 1'b0;
        memory_instr = 1'b0;
        memory_addr  = '0;
        memory_wdata = '0;
        memory_wstrb = '0;
        slave_ready  = '0;
        slave_rdata  = '0;
    endtask

    task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic instr);
        memory_valid = 1'b1;
        memory_addr  = addr;
        memory_wdata = wdata;
        memory_wstrb = wstrb;
        memory_instr = instr;
    endtask

    initial begin
        reset = 1'b0;
        quiet();
        @(negedge clock);
        chk("reset_ready", 32'(memory_ready), 32'd0);
        chk("reset_slave_valid", 32'(slave_valid), 32'd0);
        tick();
        reset = 1'b1;

        // Read from uart window, answered three cycles later
        req(32'h0010_0004, 32'h0, 4'h0, 1'b0);
        @(negedge clock);
        chk("t1_slave_valid", 32'(slave_valid), 32'h2);
        chk("t1_slave_addr", slave_addr, 32'h4);
        tick();
        quiet();
        tick();
        tick();
        slave_ready[1]    = 1'b1;
        slave_rdata[1]    = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("t1_ready", 32'(memory_ready), 32'd1);
        chk("t1_rdata", memory_rdata, 32'hDEAD_BEEF);
        chk("t1_error", 32'(memory_error), 32'd0);
        tick();
        quiet();

        // Zero-wait write to axi, then an immediate back-to-back read from rom
        req(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 1'b0);
        slave_ready[3] = 1'b1;
        slave_rdata[3] = 32'h0000_55AA;
        @(negedge clock);
        chk("t2_ready", 32'(memory_ready), 32'd1);
        chk("t2_slave_valid", 32'(slave_valid), 32'h8);
        chk("t2_slave_addr", slave_addr, 32'h10);
        tick();
        quiet();
        req(32'h0000_0100, 32'h0, 4'h0, 1'b1);
        slave_ready[0] = 1'b1;
        slave_rdata[0] = 32'h0000_0011;
        @(negedge clock);
        chk("t2_b2b_slave_valid", 32'(slave_valid), 32'h1);
        chk("t2_b2b_rdata", memory_rdata, 32'h11);
        tick();
        quiet();

        // Unmapped address: error one cycle later
        req(32'h4000_0000, 32'h0, 4'h0, 1'b0);
        @(negedge clock);
        chk("t3_slave_valid", 32'(slave_valid), 32'd0);
        chk("t3_ready_early", 32'(memory_ready), 32'd0);
        tick();
        quiet();
        @(negedge clock);
        chk("t3_ready", 32'(memory_ready), 32'd1);
        chk("t3_error", 32'(memory_error), 32'd1);
        chk("t3_rdata", memory_rdata, 32'd0);
        tick();

        // Window edges: rom top is exclusive, clint last byte maps, axi top is exclusive
        req(32'h0001_0000, 32'h0, 4'h0, 1'b0);
        tick();
        quiet();
        tick();
        req(32'h0020_BFFF, 32'h1234, 4'h3, 1'b0);
        slave_ready[2] = 1'b1;
        slave_rdata[2] = 32'h0000_BFFF;
        @(negedge clock);
        chk("edge_clint_addr", slave_addr, 32'h0000_BFFF);
        tick();
        quiet();
        req(32'h9000_0000, 32'h0, 4'h0, 1'b0);
        tick();
        quiet();
        tick();
        req(32'h8FFF_FFFF, 32'h0, 4'h0, 1'b0);
        slave_ready[3] = 1'b1;
        slave_rdata[3] = 32'h0F0F_0F0F;
        tick();
        quiet();

        // Busy on clint: stray rom ready and a protocol-violating request are ignored
        req(32'h0020_0008, 32'h0, 4'h0, 1'b0);
        tick();
        quiet();
        req(32'h0000_0000, 32'h0, 4'h0, 1'b0);
        slave_ready[0] = 1'b1;
        slave_rdata[0] = 32'h1234_5678;
        @(negedge clock);
        chk("t4_stray_ready", 32'(memory_ready), 32'd0);
        chk("t4_violation_slave_valid", 32'(slave_valid), 32'd0);
        tick();
        quiet();
        tick();
        slave_ready[2] = 1'b1;
        slave_rdata[2] = 32'hA5A5_0002;
        @(negedge clock);
        chk("t4_ready", 32'(memory_ready), 32'd1);
        chk("t4_rdata", memory_rdata, 32'hA5A5_0002);
        tick();
        quiet();

        // Silent uart: timeout after 7 cycles when enabled, otherwise a late answer lands
        req(32'h0010_0000, 32'h0, 4'h0, 1'b0);
        tick();
        quiet();
        repeat (5) tick();
        @(negedge clock);
        chk("t5_cycle6_ready", 32'(memory_ready), 32'd0);
        tick();
        @(negedge clock);
`ifdef DECODER_TIMEOUT_EN
        chk("t5_timeout_ready", 32'(memory_ready), 32'd1);
        chk("t5_timeout_error", 32'(memory_error), 32'd1);
`else
        chk("t5_cycle7_ready", 32'(memory_ready), 32'd0);
`endif
        tick();
        tick();
        slave_ready[1] = 1'b1;
        slave_rdata[1] = 32'hBEEF_0009;
        @(negedge clock);
`ifdef DECODER_TIMEOUT_EN
        chk("t5_late_ready_ignored", 32'(memory_ready), 32'd0);
`else
        chk("t5_late_ready", 32'(memory_ready), 32'd1);
        chk("t5_late_rdata", memory_rdata, 32'hBEEF_0009);
`endif
        tick();
        quiet();

        // Reset mid-BUSY abandons the request; stale ready ignored; next request normal
        req(32'h0020_0000, 32'h0, 4'h0, 1'b0);
        tick();
        quiet();
        tick();
        reset = 1'b0;
        slave_ready[2] = 1'b1;
        slave_rdata[2] = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("t6_reset_ready", 32'(memory_ready), 32'd0);
        chk("t6_reset_rdata", memory_rdata, 32'd0);
        chk("t6_reset_error", 32'(memory_error), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("t6_stale_ready", 32'(memory_ready), 32'd0);
        tick();
        quiet();
        req(32'h0000_0000, 32'h0, 4'h0, 1'b0);
        slave_ready[0] = 1'b1;
        slave_rdata[0] = 32'h0000_0077;
        @(negedge clock);
        chk("t6_after_slave_valid", 32'(slave_valid), 32'h1);
        chk("t6_after_rdata", memory_rdata, 32'h77);
        tick();
        quiet();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
